// File: rtl/move_replay_sequencer.sv
// move_replay_sequencer: records applied cube moves in a LIFO and replays their inverses newest-first.
// Define MOVE_MERGE_EN to fold a move into the top entry when both turn the same face.
module move_replay_sequencer #(
  parameter int DEPTH = 64,
  parameter int PTR_W = 6,
  parameter int GAP_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_valid,
  input  logic [2:0]       rec_face,
  input  logic [1:0]       rec_rot,
  input  logic             clear,
  input  logic             start_solve,
  input  logic             abort,
  output logic             mv_valid,
  output logic [2:0]       mv_face,
  output logic [1:0]       mv_rot,
  input  logic             mv_ready,
  output logic             busy,
  output logic             done,
  output logic [PTR_W:0]   depth,
  output logic             overflow
);
  localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FINISH} state_t;
  state_t state;
  logic [4:0] mem [DEPTH];
  logic [PTR_W:0] ptr, d_rec;
  logic [CW-1:0] cnt;
  logic [PTR_W-1:0] top_idx, waddr;
  logic [4:0] top, wdata;
  logic [1:0] mrot;
  logic rec_ok, full, merge, push, drop, we, xfer;
  always_comb begin
    top_idx = PTR_W'(ptr - 1'b1);
    top = mem[top_idx];
    full = ptr == (PTR_W+1)'(DEPTH);
    rec_ok = state == IDLE && rec_valid && rec_rot != 2'd0 && !clear;
`ifdef MOVE_MERGE_EN
    merge = rec_ok && ptr != '0 && top[4:2] == rec_face;
`else
    merge = 1'b0;
`endif
    mrot = top[1:0] + rec_rot;
    push = rec_ok && !merge && !full;
    drop = rec_ok && !merge && full;
    we = push || (merge && mrot != 2'd0);
    waddr = push ? ptr[PTR_W-1:0] : top_idx;
    wdata = push ? {rec_face, rec_rot} : {top[4:2], mrot};
    d_rec = clear ? '0 : push ? ptr + 1'b1 : (merge && mrot == 2'd0) ? ptr - 1'b1 : ptr;
    xfer = state == ISSUE && mv_valid && mv_ready;
  end
  // history storage needs no reset: the pointer alone defines which entries are live
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      mv_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        mv_valid <= 1'b0;
        if (xfer) ptr <= ptr - 1'b1;
      end else
        case (state)
          IDLE: begin
            ptr <= d_rec;
            overflow <= clear ? 1'b0 : overflow | drop;
            if (start_solve) begin
              state <= d_rec != '0 ? ISSUE : FINISH;
              mv_valid <= d_rec != '0;
            end
          end
          ISSUE:
            if (xfer) begin
              ptr <= ptr - 1'b1;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
                cnt <= CW'(GAP_CYCLES - 1);
                mv_valid <= 1'b0;
              end else if (ptr == (PTR_W+1)'(1)) begin
                state <= FINISH;
                mv_valid <= 1'b0;
              end
            end
          GAP:
            if (cnt == '0) begin
              state <= ptr != '0 ? ISSUE : FINISH;
              mv_valid <= ptr != '0;
            end else
              cnt <= cnt - 1'b1;
          FINISH: begin
            state <= IDLE;
            done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
    end
  assign busy = state != IDLE;
  assign depth = ptr;
  assign mv_face = mv_valid ? top[4:2] : 3'd0;
  assign mv_rot = mv_valid ? 2'd0 - top[1:0] : 2'd0;
endmodule

// File: tb/tb_move_replay_sequencer.sv
// tb_move_replay_sequencer: directed stimulus against a queue-based model of the replay sequencer.
module tb_move_replay_sequencer;
  localparam int G = 2;
  logic clk = 0, rst = 1;
  logic rec_valid = 0, clear = 0, start_solve = 0, abort = 0, mv_ready = 0;
  logic [2:0] rec_face = 0;
  logic [1:0] rec_rot = 0;
  logic mv_valid, busy, done, overflow;
  logic [2:0] mv_face;
  logic [1:0] mv_rot;
  logic [6:0] depth;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  int lf[$], lr[$], lc[$];
  logic [4:0] q[$];
  logic [4:0] t;
  logic m_valid = 0, m_fin = 0, m_done = 0, m_ovf = 0;
  int m_gap = 0;

  move_replay_sequencer #(.DEPTH(64), .PTR_W(6), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_face(rec_face), .rec_rot(rec_rot),
    .clear(clear), .start_solve(start_solve), .abort(abort), .mv_valid(mv_valid),
    .mv_face(mv_face), .mv_rot(mv_rot), .mv_ready(mv_ready), .busy(busy), .done(done),
    .depth(depth), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic m_busy();
    return m_valid || m_gap > 0 || m_fin;
  endfunction

  // model: history is a queue, replay is tracked as pending-command / gap timer / finish flag
  always @(posedge clk or posedge rst) begin
    logic [4:0] tp;
    int r;
    if (rst) begin
      q.delete();
      m_valid = 0; m_fin = 0; m_done = 0; m_ovf = 0; m_gap = 0;
    end else begin
      m_done = 0;
      if (!m_busy()) begin
        if (clear) begin
          q.delete();
          m_ovf = 0;
        end else if (rec_valid && rec_rot != 0) begin
          tp = q.size() > 0 ? q[$] : 5'd0;
`ifdef MOVE_MERGE_EN
          if (q.size() > 0 && tp[4:2] == rec_face) begin
            r = (int'(tp[1:0]) + int'(rec_rot)) % 4;
            if (r == 0) void'(q.pop_back());
            else q[$] = {rec_face, 2'(r)};
          end else
`endif
          if (q.size() == 64) m_ovf = 1;
          else q.push_back({rec_face, rec_rot});
        end
        if (start_solve) begin
          if (q.size() > 0) m_valid = 1;
          else m_fin = 1;
        end
      end else if (abort) begin
        if (m_valid && mv_ready) void'(q.pop_back());
        m_valid = 0; m_gap = 0; m_fin = 0;
      end else if (m_fin) begin
        m_fin = 0;
        m_done = 1;
      end else if (m_valid) begin
        if (mv_ready) begin
          void'(q.pop_back());
          if (G > 0) begin
            m_valid = 0;
            m_gap = G;
          end else if (q.size() == 0) begin
            m_valid = 0;
            m_fin = 1;
          end
        end
      end else begin
        m_gap--;
        if (m_gap == 0) begin
          if (q.size() > 0) m_valid = 1;
          else m_fin = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mv_valid", mv_valid, m_valid);
    chk("busy", busy, m_busy());
    chk("done", done, m_done);
    chk("depth", depth, q.size());
    chk("overflow", overflow, m_ovf);
    if (m_valid && q.size() > 0) begin
      t = q[$];
      chk("mv_face", mv_face, t[4:2]);
      chk("mv_rot", mv_rot, (4 - int'(t[1:0])) % 4);
    end
    if (mv_valid && mv_ready) begin
      lf.push_back(mv_face);
      lr.push_back(mv_rot);
      lc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int f, input int r);
    rec_valid = 1; rec_face = 3'(f); rec_rot = 2'(r);
    tick();
    rec_valid = 0;
  endtask

  task automatic start();
    start_solve = 1;
    tick();
    start_solve = 0;
  endtask

  task automatic clr_log();
    lf.delete(); lr.delete(); lc.delete();
  endtask

  task automatic wait_done(input int lim);
    int c = done_cnt;
    int n = 0;
    while (done_cnt == c && n < lim) begin
      tick();
      n++;
    end
    tick();
    chk("done_seen", done_cnt - c, 1);
  endtask

  task automatic exp_xfer(input int i, input int f, input int r);
    chk("xfer_face", i < lf.size() ? lf[i] : -1, f);
    chk("xfer_rot", i < lr.size() ? lr[i] : -1, r);
  endtask

  task automatic exp_gap(input int i);
    chk("xfer_spacing", i + 1 < lc.size() ? lc[i+1] - lc[i] : -1, G + 1);
  endtask

  initial begin
    int s;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_depth", depth, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", mv_valid, 0);
    // basic replay
    rec(0, 1); rec(3, 2); rec(5, 3);
    chk("t1_depth", depth, 3);
    clr_log();
    mv_ready = 1;
    start();
    wait_done(100);
    chk("t1_count", lf.size(), 3);
    exp_xfer(0, 5, 1); exp_xfer(1, 3, 2); exp_xfer(2, 0, 3);
    exp_gap(0); exp_gap(1);
    chk("t1_done_offset", lc.size() > 0 ? done_cyc - lc[0] : -1, 3 * G + 4);
    chk("t1_depth_end", depth, 0);
    chk("t1_busy_end", busy, 0);
    mv_ready = 0;
    // overflow and clear
    for (int i = 0; i < 65; i++) rec(i % 6, 1 + i % 3);
    chk("ovf_depth", depth, 64);
    chk("ovf_flag", overflow, 1);
    clear = 1; rec_valid = 1; rec_face = 1; rec_rot = 1;
    tick();
    clear = 0; rec_valid = 0;
    chk("clr_depth", depth, 0);
    chk("clr_flag", overflow, 0);
    // back-pressure on the first command
    rec(1, 1); rec(2, 2); rec(4, 3);
    clr_log();
    start();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", mv_valid, 1);
      chk("bp_face", mv_face, 4);
      chk("bp_rot", mv_rot, 1);
      tick();
    end
    mv_ready = 1;
    wait_done(100);
    chk("bp_count", lf.size(), 3);
    exp_xfer(0, 4, 1); exp_xfer(1, 2, 2); exp_xfer(2, 1, 3);
    exp_gap(0); exp_gap(1);
    // abort after the first transfer, then resume
    rec(0, 1); rec(1, 2); rec(2, 3); rec(3, 1);
    clr_log();
    start();
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("ab_busy", busy, 0);
    chk("ab_valid", mv_valid, 0);
    chk("ab_depth", depth, 3);
    chk("ab_count", lf.size(), 1);
    exp_xfer(0, 3, 3);
    clr_log();
    start();
    wait_done(100);
    chk("ab_resume_count", lf.size(), 3);
    exp_xfer(0, 2, 1); exp_xfer(1, 1, 2); exp_xfer(2, 0, 3);
    // abort coinciding with a transfer still pops
    rec(5, 2); rec(4, 1);
    start();
    abort = 1;
    tick();
    abort = 0;
    chk("abx_depth", depth, 1);
    chk("abx_busy", busy, 0);
    clear = 1;
    tick();
    clear = 0;
    // empty replay
    clr_log();
    s = cyc;
    start();
    wait_done(20);
    chk("empty_done_offset", done_cyc - s, 2);
    chk("empty_count", lf.size(), 0);
    // merge behaviour
    mv_ready = 0;
    rec(2, 1); rec(2, 1);
`ifdef MOVE_MERGE_EN
    chk("mg_depth2", depth, 1);
    start();
    chk("mg_top_rot", mv_rot, 2);
`else
    chk("mg_depth2", depth, 2);
    start();
    chk("mg_top_rot", mv_rot, 3);
`endif
    abort = 1;
    tick();
    abort = 0;
    rec(2, 2);
`ifdef MOVE_MERGE_EN
    chk("mg_depth3", depth, 0);
`else
    chk("mg_depth3", depth, 3);
`endif
    // reset mid-replay
    rec(1, 1); rec(3, 1);
    start();
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("rr_depth", depth, 0);
    chk("rr_busy", busy, 0);
    chk("rr_valid", mv_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
